instr_decode_stage: RTL
=======================

// Module: instr_decode_stage
// PURPOSE
//  Registered, parametrised MIPS-style instruction decode stage for the CPU front end.
//  Splits a fetched word into op/rs/rt/rd/shamt/func/imm/target and classifies it as R/I/J.
//  Produces an extended immediate and flags illegal opcodes.
//  Sits between fetch and register read, with valid/ready on both sides and a DEPTH-entry output buffer.
// PARAMETERS
//  XLEN     32  instruction and immediate-extension width
//  OP_W      6  opcode field width, field at [XLEN-1 -: OP_W]
//  REG_W     5  rs/rt/rd field width
//  SHAMT_W   5  shift-amount field width
//  FUNC_W    6  function field width, at [FUNC_W-1:0]
//  IMM_W    16  immediate field width, at [IMM_W-1:0]
//  DEPTH     2  output buffer entries (>=1); 2 gives full throughput without a ready path
//  Elaboration check: OP_W+3*REG_W+SHAMT_W+FUNC_W==XLEN and OP_W+2*REG_W+IMM_W==XLEN, else $error.
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous reset, active-high
//  flush      in   1              synchronous flush of all buffered entries
//  in_valid   in   1              in_instr is valid
//  in_ready   out  1              stage accepts in_instr this cycle
//  in_instr   in   XLEN           raw instruction word
//  out_valid  out  1              head entry is valid
//  out_ready  in   1              consumer takes the head entry
//  out_op     out  OP_W           opcode
//  out_rs     out  REG_W          source register
//  out_rt     out  REG_W          second source/target register
//  out_rd     out  REG_W          destination register (R-type)
//  out_shamt  out  SHAMT_W        shift amount
//  out_func   out  FUNC_W         function code
//  out_imm    out  XLEN           extended immediate
//  out_target out  XLEN-OP_W      jump target field
//  out_type   out  2              00=R, 01=I, 10=J, 11=illegal
//  out_illegal out 1              opcode not in the legal set
//  dec_count  out  32             instructions accepted since reset (wraps)
// BEHAVIOUR
//  - Reset: count=0, out_valid=0, in_ready=1, all out_* fields 0, dec_count=0. Reset mid-transfer drops every entry.
//  - Accept when in_valid&&in_ready. in_ready = (count!=DEPTH); registered, no combinational path from out_ready.
//  - Latency: a word accepted at edge N appears at the head at edge N+1 if the buffer was empty.
//  - Pop when out_valid&&out_ready. Push and pop in the same cycle leave count unchanged and keep order (FIFO).
//  - Full (count==DEPTH): in_ready=0 and in_instr is ignored. Empty: out_valid=0 and out_* hold the last head value.
//  - flush: highest priority. Next count=0 and any push in the same cycle is dropped. dec_count is not reset and does not count the dropped word.
//  - dec_count increments once per accepted word; it wraps 2^32-1 -> 0.
//  - Classification: op==0 -> R. op in {0x02,0x03} -> J. Op in legal I set -> I.
//    Any other op -> type 11 with out_illegal=1; fields are still extracted.
//  - Legal I set: 04,05,08-0F,20,21,23,24,25,28,29,2B (hex).
//  - out_imm: zero-extended for op 0x0C/0x0D/0x0E (andi/ori/xori). Sign-extended from bit IMM_W-1 otherwise.
//    For J and R types out_imm still carries the sign-extended low field.
//  - Decode is computed at push time, so the buffer stores decoded entries.
// STRUCTURE
//  - Package decode_pkg: opcode localparams, type encoding (TYPE_R/I/J/ILL), decoded-entry struct/width.
//  - Sub-module instr_field_extract: combinational word -> decoded entry.
//  - Top holds the circular buffer (rd/wr pointers, count) and dec_count.
// TESTING
//  1. Push 32'h014B4820 with out_ready=1 -> next cycle R, rs=10, rt=11, rd=9, shamt=0, func=0x20, illegal=0.
//  2. Push 32'h2108FFFF (addi) -> I, imm=32'hFFFFFFFF. Push 32'h3508FFFF (ori) -> imm=32'h0000FFFF.
//  3. Push 32'h08100000 -> J, target=26'h0100000. Push 32'hFC000000 -> type=11, illegal=1.
//  4. out_ready=0, push 3 back-to-back words -> first two accepted, in_ready=0 on the third.
//     Then out_ready=1 -> the words emerge in order, one per cycle, and the third is then accepted.
//  5. Buffer holds 2 entries, assert flush together with in_valid -> out_valid=0 next cycle, pushed word dropped, dec_count unchanged by it.
//  6. Assert rst asynchronously mid-stream -> outputs 0 immediately, dec_count=0; after release, 32'h8C280020 decodes as I, rs=1, rt=8, imm=32'h20.
//  Bench also checks FIFO order and count under random valid/ready against a reference model.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode constants, type encodings and decoded-entry sizing for the
// instruction decode stage.
package decode_pkg;

    localparam logic [1:0] TYPE_R   = 2'b00;
    localparam logic [1:0] TYPE_I   = 2'b01;
    localparam logic [1:0] TYPE_J   = 2'b10;
    localparam logic [1:0] TYPE_ILL = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    function automatic logic is_legal_i(input logic [5:0] op);
        case (op)
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Packed entry: {op, rs, rt, rd, shamt, func, imm, target, type, illegal}
    function automatic int entry_width(input int xlen, input int op_w, input int reg_w,
                                       input int shamt_w, input int func_w);
        return op_w + 3 * reg_w + shamt_w + func_w + xlen + (xlen - op_w) + 3;
    endfunction

endpackage

// File: rtl/instr_field_extract.sv
// Combinational split of a raw instruction word into its fields, R/I/J
// classification and the extended immediate.
module instr_field_extract
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int OP_W    = 6,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int FUNC_W  = 6,
    parameter int IMM_W   = 16
) (
    input  logic [XLEN-1:0]      instr,
    output logic [OP_W-1:0]      op,
    output logic [REG_W-1:0]     rs,
    output logic [REG_W-1:0]     rt,
    output logic [REG_W-1:0]     rd,
    output logic [SHAMT_W-1:0]   shamt,
    output logic [FUNC_W-1:0]    func,
    output logic [XLEN-1:0]      imm,
    output logic [XLEN-OP_W-1:0] target,
    output logic [1:0]           typ,
    output logic                 illegal
);

    logic [5:0]       op6;
    logic [IMM_W-1:0] imm_field;

    assign op        = instr[XLEN-1 -: OP_W];
    assign rs        = instr[XLEN-OP_W-1 -: REG_W];
    assign rt        = instr[XLEN-OP_W-REG_W-1 -: REG_W];
    assign rd        = instr[XLEN-OP_W-2*REG_W-1 -: REG_W];
    assign shamt     = instr[FUNC_W +: SHAMT_W];
    assign func      = instr[FUNC_W-1:0];
    assign target    = instr[XLEN-OP_W-1:0];
    assign imm_field = instr[IMM_W-1:0];
    assign op6       = 6'(op);

    // Classify the opcode and pick zero- or sign-extension for the immediate
    always_comb begin
        typ = TYPE_ILL;
        if (op6 == OP_RTYPE) begin
            typ = TYPE_R;
        end else if (op6 == OP_J || op6 == OP_JAL) begin
            typ = TYPE_J;
        end else if (is_legal_i(op6)) begin
            typ = TYPE_I;
        end else begin
            typ = TYPE_ILL;
        end
        illegal = (typ == TYPE_ILL);
        if (op6 == OP_ANDI || op6 == OP_ORI || op6 == OP_XORI) begin
            imm = {{(XLEN-IMM_W){1'b0}}, imm_field};
        end else begin
            imm = {{(XLEN-IMM_W){imm_field[IMM_W-1]}}, imm_field};
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decodes at push time into a DEPTH-entry circular
// buffer whose head is held in an output register.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int OP_W    = 6,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int FUNC_W  = 6,
    parameter int IMM_W   = 16,
    parameter int DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      out_op,
    output logic [REG_W-1:0]     out_rs,
    output logic [REG_W-1:0]     out_rt,
    output logic [REG_W-1:0]     out_rd,
    output logic [SHAMT_W-1:0]   out_shamt,
    output logic [FUNC_W-1:0]    out_func,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-OP_W-1:0] out_target,
    output logic [1:0]           out_type,
    output logic                 out_illegal,
    output logic [31:0]          dec_count
);

    localparam int ENTRY_W = entry_width(XLEN, OP_W, REG_W, SHAMT_W, FUNC_W);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    if (OP_W + 3*REG_W + SHAMT_W + FUNC_W != XLEN || OP_W + 2*REG_W + IMM_W != XLEN) begin : g_bad_layout
        $error("instr_decode_stage: field widths do not add up to XLEN");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("instr_decode_stage: DEPTH must be at least 1");
    end

    logic [OP_W-1:0]      dec_op;
    logic [REG_W-1:0]     dec_rs, dec_rt, dec_rd;
    logic [SHAMT_W-1:0]   dec_shamt;
    logic [FUNC_W-1:0]    dec_func;
    logic [XLEN-1:0]      dec_imm;
    logic [XLEN-OP_W-1:0] dec_target;
    logic [1:0]           dec_typ;
    logic                 dec_illegal;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] new_entry_s, head_r, next_head_s;
    logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r, next_rd_ptr_s, next_wr_ptr_s;
    logic [CNT_W-1:0]   count_r, kept_s, next_count_s;
    logic               push_s, pop_s, in_ready_r, out_valid_r;
    logic [31:0]        dec_count_r;

    instr_field_extract #(
        .XLEN(XLEN), .OP_W(OP_W), .REG_W(REG_W),
        .SHAMT_W(SHAMT_W), .FUNC_W(FUNC_W), .IMM_W(IMM_W)
    ) u_extract (
        .instr(in_instr), .op(dec_op), .rs(dec_rs), .rt(dec_rt), .rd(dec_rd),
        .shamt(dec_shamt), .func(dec_func), .imm(dec_imm), .target(dec_target),
        .typ(dec_typ), .illegal(dec_illegal)
    );

    assign new_entry_s = {dec_op, dec_rs, dec_rt, dec_rd, dec_shamt, dec_func,
                          dec_imm, dec_target, dec_typ, dec_illegal};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Next buffer state; the head register follows whichever entry is at the front after this edge
    always_comb begin
        push_s        = in_valid && in_ready_r && !flush;
        pop_s         = out_valid_r && out_ready && !flush;
        kept_s        = count_r - CNT_W'(pop_s);
        next_rd_ptr_s = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        next_wr_ptr_s = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        next_count_s  = kept_s + CNT_W'(push_s);
        next_head_s   = head_r;
        if (flush) begin
            next_rd_ptr_s = '0;
            next_wr_ptr_s = '0;
            next_count_s  = '0;
        end else if (push_s && kept_s == '0) begin
            next_head_s = new_entry_s;
        end else if (kept_s != '0) begin
            next_head_s = mem[next_rd_ptr_s];
        end else begin
            next_head_s = head_r;
        end
    end

    // Buffer storage; contents are only meaningful below count, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_r] <= new_entry_s;
        end
    end

    // Control state, head register and accepted-word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= '0;
            dec_count_r <= 32'd0;
        end else begin
            rd_ptr_r    <= next_rd_ptr_s;
            wr_ptr_r    <= next_wr_ptr_s;
            count_r     <= next_count_s;
            in_ready_r  <= (next_count_s != CNT_W'(DEPTH));
            out_valid_r <= (next_count_s != '0);
            head_r      <= next_head_s;
            if (push_s) begin
                dec_count_r <= dec_count_r + 32'd1;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign dec_count = dec_count_r;
    assign {out_op, out_rs, out_rt, out_rd, out_shamt, out_func,
            out_imm, out_target, out_type, out_illegal} = head_r;

endmodule
